accel_bus_endpoint: RTL and testbench

- Accelerator-side endpoint of the CPU↔accelerator bus; the responder for the CPU's bus_data_out / bus_data_in path.
- Buffers 16-bit command words written by the CPU, frames them into header+payload packets and streams them to the accelerator core over a valid/ready interface.
- Collects accelerator result words in a FIFO and presents the head word to the CPU's writeback mux.

---
 rtl/accel_bus_endpoint.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_accel_bus_endpoint.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_bus_endpoint.sv
// ---------------------------------------------------------------------------
// accel_bus_endpoint
//
// Accelerator-side endpoint of the CPU <-> accelerator bus. The CPU writes
// 16-bit command words into a command FIFO. The words are streamed to the
// accelerator core over a valid/ready interface, tagged as header or payload
// by a small framing FSM. Result words from the accelerator are collected in
// a result FIFO, and its head word is presented to the CPU writeback mux.
//
// Optional feature macro: ACCEL_BUS_STATUS_EN
//   Defined   -> adds the cpu_status_o readback word and the cpu_status_clr_i
//                input, which clears the sticky error flags.
//   Undefined -> neither port exists; error flags clear only on reset.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   cpu_status_o        (optional) {ovf, unf, in_payload, 0, cmd_cnt, res_cnt}
//   cpu_status_clr_i    (optional) clear sticky error flags
//   cpu_wr_en_i         CPU pushes cpu_wr_data_i this cycle
//   cpu_wr_data_i       command word from the CPU
//   cpu_rd_en_i         CPU consumed cpu_rd_data_o (pop)
//   cpu_rd_data_o       result FIFO head; 0 when empty
//   cpu_wr_full_o       command FIFO full
//   cpu_rd_empty_o      result FIFO empty
//   acc_cmd_valid_o     command word available
//   acc_cmd_ready_i     accelerator accepts command word
//   acc_cmd_data_o      command word
//   acc_cmd_hdr_o       current word is a packet header
//   acc_cmd_last_o      current word is the last word of its packet
//   acc_res_valid_i     accelerator offers a result word
//   acc_res_ready_o     endpoint accepts the result word
//   acc_res_data_i      result word
//   err_overflow_o      sticky: write to a full command FIFO
//   err_underflow_o     sticky: pop of an empty result FIFO
//   busy_o              command FIFO non-empty or packet in progress
// ---------------------------------------------------------------------------
module accel_bus_endpoint #(
    parameter int DW        = 16,
    parameter int CMD_DEPTH = 8,
    parameter int RES_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef ACCEL_BUS_STATUS_EN
    output logic [15:0]   cpu_status_o,
    input  logic          cpu_status_clr_i,
`endif
    input  logic          cpu_wr_en_i,
    input  logic [DW-1:0] cpu_wr_data_i,
    input  logic          cpu_rd_en_i,
    output logic [DW-1:0] cpu_rd_data_o,
    output logic          cpu_wr_full_o,
    output logic          cpu_rd_empty_o,
    output logic          acc_cmd_valid_o,
    input  logic          acc_cmd_ready_i,
    output logic [DW-1:0] acc_cmd_data_o,
    output logic          acc_cmd_hdr_o,
    output logic          acc_cmd_last_o,
    input  logic          acc_res_valid_i,
    output logic          acc_res_ready_o,
    input  logic [DW-1:0] acc_res_data_i,
    output logic          err_overflow_o,
    output logic          err_underflow_o,
    output logic          busy_o
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int CCW = CAW + 1;
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int RCW = RAW + 1;

    localparam logic [CCW-1:0] CMD_FULL_CNT = CCW'(CMD_DEPTH);
    localparam logic [RCW-1:0] RES_FULL_CNT = RCW'(RES_DEPTH);

    typedef enum logic {
        S_HDR = 1'b0,
        S_PAY = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Command FIFO
    // -----------------------------------------------------------------------
    logic [DW-1:0]  cmdMem_q [CMD_DEPTH];
    logic [CAW-1:0] cmdWrPtr_q, cmdWrPtr_d;
    logic [CAW-1:0] cmdRdPtr_q, cmdRdPtr_d;
    logic [CCW-1:0] cmdCount_q, cmdCount_d;
    logic           cmdEmpty;
    logic           cmdFull;
    logic           cmdPush;
    logic           cmdPop;
    logic [DW-1:0]  cmdHead;

    assign cmdEmpty = (cmdCount_q == '0);
    assign cmdFull  = (cmdCount_q == CMD_FULL_CNT);
    assign cmdHead  = cmdMem_q[cmdRdPtr_q];
    assign cmdPop   = !cmdEmpty && acc_cmd_ready_i;
    // A write at full is still taken when the head leaves in the same cycle.
    assign cmdPush  = cpu_wr_en_i && (!cmdFull || cmdPop);

    always_comb begin
        cmdWrPtr_d = cmdWrPtr_q;
        cmdRdPtr_d = cmdRdPtr_q;
        cmdCount_d = cmdCount_q;
        if (cmdPush) begin
            cmdWrPtr_d = cmdWrPtr_q + 1'b1;
        end
        if (cmdPop) begin
            cmdRdPtr_d = cmdRdPtr_q + 1'b1;
        end
        if (cmdPush && !cmdPop) begin
            cmdCount_d = cmdCount_q + 1'b1;
        end else if (!cmdPush && cmdPop) begin
            cmdCount_d = cmdCount_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmdWrPtr_q <= '0;
            cmdRdPtr_q <= '0;
            cmdCount_q <= '0;
        end else begin
            cmdWrPtr_q <= cmdWrPtr_d;
            cmdRdPtr_q <= cmdRdPtr_d;
            cmdCount_q <= cmdCount_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (cmdPush) begin
            cmdMem_q[cmdWrPtr_q] <= cpu_wr_data_i;
        end
    end

    // -----------------------------------------------------------------------
    // Framing FSM
    // -----------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        isHdr;
    logic        isLast;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        isHdr   = 1'b0;
        isLast  = 1'b0;
        case (state_q)
            S_HDR: begin
                isHdr  = 1'b1;
                isLast = (cmdHead[11:0] == 12'd0);
                if (cmdPop && (cmdHead[11:0] != 12'd0)) begin
                    cnt_d   = cmdHead[11:0];
                    state_d = S_PAY;
                end
            end
            S_PAY: begin
                isLast = (cnt_q == 12'd1);
                if (cmdPop) begin
                    cnt_d = cnt_q - 12'd1;
                    if (cnt_q == 12'd1) begin
                        state_d = S_HDR;
                    end
                end
            end
            default: begin
                state_d = S_HDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Head word, hdr and last are masked while empty so that an idle or
    // freshly reset endpoint drives all-zero command outputs.
    assign acc_cmd_valid_o = !cmdEmpty;
    assign acc_cmd_data_o  = cmdEmpty ? '0 : cmdHead;
    assign acc_cmd_hdr_o   = !cmdEmpty && isHdr;
    assign acc_cmd_last_o  = !cmdEmpty && isLast;
    assign cpu_wr_full_o   = cmdFull;
    assign busy_o          = !cmdEmpty || (state_q == S_PAY);

    // -----------------------------------------------------------------------
    // Result FIFO
    // -----------------------------------------------------------------------
    logic [DW-1:0]  resMem_q [RES_DEPTH];
    logic [RAW-1:0] resWrPtr_q, resWrPtr_d;
    logic [RAW-1:0] resRdPtr_q, resRdPtr_d;
    logic [RCW-1:0] resCount_q, resCount_d;
    logic           resEmpty;
    logic           resFull;
    logic           resPush;
    logic           resPop;

    assign resEmpty = (resCount_q == '0);
    assign resFull  = (resCount_q == RES_FULL_CNT);
    assign resPop   = cpu_rd_en_i && !resEmpty;
    // Ready also rises at full when the CPU pops in the same cycle, so the
    // freed slot is refilled without a bubble.
    assign acc_res_ready_o = !resFull || resPop;
    assign resPush         = acc_res_valid_i && acc_res_ready_o;

    always_comb begin
        resWrPtr_d = resWrPtr_q;
        resRdPtr_d = resRdPtr_q;
        resCount_d = resCount_q;
        if (resPush) begin
            resWrPtr_d = resWrPtr_q + 1'b1;
        end
        if (resPop) begin
            resRdPtr_d = resRdPtr_q + 1'b1;
        end
        if (resPush && !resPop) begin
            resCount_d = resCount_q + 1'b1;
        end else if (!resPush && resPop) begin
            resCount_d = resCount_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resWrPtr_q <= '0;
            resRdPtr_q <= '0;
            resCount_q <= '0;
        end else begin
            resWrPtr_q <= resWrPtr_d;
            resRdPtr_q <= resRdPtr_d;
            resCount_q <= resCount_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resPush) begin
            resMem_q[resWrPtr_q] <= acc_res_data_i;
        end
    end

    // The CPU writeback mux ORs sources together, so an empty FIFO shows 0.
    assign cpu_rd_data_o  = resEmpty ? '0 : resMem_q[resRdPtr_q];
    assign cpu_rd_empty_o = resEmpty;

    // -----------------------------------------------------------------------
    // Sticky error flags
    // -----------------------------------------------------------------------
    logic errOvf_q, errOvf_d;
    logic errUnf_q, errUnf_d;
    logic ovfSet;
    logic unfSet;

    assign ovfSet = cpu_wr_en_i && cmdFull && !cmdPop;
    assign unfSet = cpu_rd_en_i && resEmpty;

    // A new error event wins over a simultaneous clear.
    always_comb begin
`ifdef ACCEL_BUS_STATUS_EN
        errOvf_d = ovfSet || (errOvf_q && !cpu_status_clr_i);
        errUnf_d = unfSet || (errUnf_q && !cpu_status_clr_i);
`else
        errOvf_d = ovfSet || errOvf_q;
        errUnf_d = unfSet || errUnf_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errOvf_q <= 1'b0;
            errUnf_q <= 1'b0;
        end else begin
            errOvf_q <= errOvf_d;
            errUnf_q <= errUnf_d;
        end
    end

    assign err_overflow_o  = errOvf_q;
    assign err_underflow_o = errUnf_q;

`ifdef ACCEL_BUS_STATUS_EN
    assign cpu_status_o = {errOvf_q, errUnf_q, (state_q == S_PAY), 1'b0,
                           6'(cmdCount_q), 6'(resCount_q)};
`endif

endmodule

// File: tb/tb_accel_bus_endpoint.sv
// ---------------------------------------------------------------------------
// tb_accel_bus_endpoint
//
// Self-checking bench for accel_bus_endpoint (default depths of 8). A table
// of per-cycle command vectors covers packet framing and the held-valid
// case; hand-written sequences cover command overflow, result FIFO ordering,
// underflow, simultaneous push/pop at full, and reset in mid-packet.
// ---------------------------------------------------------------------------
module tb_accel_bus_endpoint;

    logic        clk;
    logic        rst_n;
    logic        cpuWrEn;
    logic [15:0] cpuWrData;
    logic        cpuRdEn;
    logic [15:0] cpuRdData;
    logic        cpuWrFull;
    logic        cpuRdEmpty;
    logic        accCmdValid;
    logic        accCmdReady;
    logic [15:0] accCmdData;
    logic        accCmdHdr;
    logic        accCmdLast;
    logic        accResValid;
    logic        accResReady;
    logic [15:0] accResData;
    logic        errOverflow;
    logic        errUnderflow;
    logic        busy;
`ifdef ACCEL_BUS_STATUS_EN
    logic [15:0] cpuStatus;
    logic        cpuStatusClr;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    accel_bus_endpoint #(
        .DW        (16),
        .CMD_DEPTH (8),
        .RES_DEPTH (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
`ifdef ACCEL_BUS_STATUS_EN
        .cpu_status_o    (cpuStatus),
        .cpu_status_clr_i(cpuStatusClr),
`endif
        .cpu_wr_en_i     (cpuWrEn),
        .cpu_wr_data_i   (cpuWrData),
        .cpu_rd_en_i     (cpuRdEn),
        .cpu_rd_data_o   (cpuRdData),
        .cpu_wr_full_o   (cpuWrFull),
        .cpu_rd_empty_o  (cpuRdEmpty),
        .acc_cmd_valid_o (accCmdValid),
        .acc_cmd_ready_i (accCmdReady),
        .acc_cmd_data_o  (accCmdData),
        .acc_cmd_hdr_o   (accCmdHdr),
        .acc_cmd_last_o  (accCmdLast),
        .acc_res_valid_i (accResValid),
        .acc_res_ready_o (accResReady),
        .acc_res_data_i  (accResData),
        .err_overflow_o  (errOverflow),
        .err_underflow_o (errUnderflow),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One command-path cycle: inputs applied, then the expected outputs
    // {valid, data, hdr, last, busy, full} seen before the next rising edge.
    typedef struct {
        logic        wrEn;
        logic [15:0] wrData;
        logic        cmdReady;
        logic [20:0] expCmd;
    } cmdVec_t;

    function automatic logic [20:0] packCmd(input logic v, input logic [15:0] d,
                                            input logic h, input logic l,
                                            input logic b, input logic f);
        return {v, d, h, l, b, f};
    endfunction

    function automatic logic [20:0] actCmd();
        return {accCmdValid, accCmdData, accCmdHdr, accCmdLast, busy, cpuWrFull};
    endfunction

    // {cmd bundle, rd data, rd empty, res ready, ovf, unf}
    function automatic logic [40:0] actAll();
        return {actCmd(), cpuRdData, cpuRdEmpty, accResReady, errOverflow, errUnderflow};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Applies one cycle of inputs at the falling edge and lets outputs settle.
    task automatic applyStimulus(input logic wrEn, input logic [15:0] wrData,
                                 input logic cmdReady, input logic resValid,
                                 input logic [15:0] resData, input logic rdEn);
        @(negedge clk);
        cpuWrEn     = wrEn;
        cpuWrData   = wrData;
        accCmdReady = cmdReady;
        accResValid = resValid;
        accResData  = resData;
        cpuRdEn     = rdEn;
        #1;
    endtask

    task automatic clearInputs();
        cpuWrEn     = 1'b0;
        cpuWrData   = 16'h0000;
        accCmdReady = 1'b0;
        accResValid = 1'b0;
        accResData  = 16'h0000;
        cpuRdEn     = 1'b0;
    endtask

    task automatic doReset(input string name);
        @(negedge clk);
        clearInputs();
        rst_n = 1'b0;
        #1;
        checkOutput(name, 64'(actAll()), 64'({21'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    cmdVec_t     vecs [11];
    logic [15:0] drainExp [8];

    initial begin
        rst_n = 1'b1;
        clearInputs();
`ifdef ACCEL_BUS_STATUS_EN
        cpuStatusClr = 1'b0;
`endif

        // ---- framing vectors ------------------------------------------------
        // Header 3002 + AAAA, BBBB streamed with ready high
        vecs[0]  = '{1'b1, 16'h3002, 1'b0, packCmd(0, 16'h0000, 0, 0, 0, 0)};
        vecs[1]  = '{1'b1, 16'hAAAA, 1'b1, packCmd(1, 16'h3002, 1, 0, 1, 0)};
        vecs[2]  = '{1'b1, 16'hBBBB, 1'b1, packCmd(1, 16'hAAAA, 0, 0, 1, 0)};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, packCmd(1, 16'hBBBB, 0, 1, 1, 0)};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, packCmd(0, 16'h0000, 0, 0, 0, 0)};
        // Zero-length header 5000 held for 3 cycles, accepted on first ready
        vecs[5]  = '{1'b1, 16'h5000, 1'b0, packCmd(0, 16'h0000, 0, 0, 0, 0)};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, packCmd(1, 16'h5000, 1, 1, 1, 0)};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, packCmd(1, 16'h5000, 1, 1, 1, 0)};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, packCmd(1, 16'h5000, 1, 1, 1, 0)};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, packCmd(1, 16'h5000, 1, 1, 1, 0)};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, packCmd(0, 16'h0000, 0, 0, 0, 0)};

        doReset("reset_initial");

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].wrEn, vecs[i].wrData, vecs[i].cmdReady,
                          1'b0, 16'h0000, 1'b0);
            checkOutput($sformatf("frame_vec%0d", i), 64'(actCmd()), 64'(vecs[i].expCmd));
        end

        // ---- command overflow and push/pop at full -------------------------
        doReset("reset_ovf");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 16'h0000, 1'b0);
        end
        // Full: write with a simultaneous pop is taken, no overflow
        applyStimulus(1'b1, 16'h0DDD, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("ovf_full_head", 64'({accCmdValid, accCmdData, cpuWrFull, errOverflow}),
                    64'({1'b1, 16'h0100, 1'b1, 1'b0}));
        // Full with no pop: word dropped
        applyStimulus(1'b1, 16'h0EEE, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("ovf_still_clear", 64'({cpuWrFull, errOverflow}), 64'({1'b1, 1'b0}));
        drainExp = '{16'h0101, 16'h0102, 16'h0103, 16'h0104,
                     16'h0105, 16'h0106, 16'h0107, 16'h0DDD};
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
            if (k == 0) checkOutput("ovf_sticky_set", 64'(errOverflow), 64'(1'b1));
            checkOutput($sformatf("ovf_drain%0d", k), 64'({accCmdValid, accCmdData}),
                        64'({1'b1, drainExp[k]}));
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("ovf_drained", 64'({accCmdValid, cpuWrFull, errOverflow}),
                    64'({1'b0, 1'b0, 1'b1}));

        // ---- result FIFO order, empty-reads-zero, underflow ----------------
        doReset("reset_res");
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0);
        checkOutput("res_idle", 64'({accResReady, cpuRdEmpty, cpuRdData}),
                    64'({1'b1, 1'b1, 16'h0000}));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h5678, 1'b0);
        checkOutput("res_latency", 64'({cpuRdEmpty, cpuRdData}), 64'({1'b0, 16'h1234}));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("res_head0", 64'(cpuRdData), 64'(16'h1234));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("res_head1", 64'(cpuRdData), 64'(16'h5678));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("res_empty", 64'({cpuRdEmpty, cpuRdData, errUnderflow}),
                    64'({1'b1, 16'h0000, 1'b0}));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("res_underflow", 64'({cpuRdEmpty, cpuRdData, errUnderflow}),
                    64'({1'b1, 16'h0000, 1'b1}));

        // ---- result FIFO full with simultaneous push and pop ---------------
        doReset("reset_resfull");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'hA000 + 16'(i), 1'b0);
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'hA0FF, 1'b0);
        checkOutput("resfull_refuse", 64'(accResReady), 64'(1'b0));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'hA008, 1'b1);
        checkOutput("resfull_pushpop", 64'({accResReady, cpuRdData}), 64'({1'b1, 16'hA000}));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("resfull_stays_full", 64'({accResReady, cpuRdData}),
                    64'({1'b0, 16'hA001}));
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
            checkOutput($sformatf("resfull_drain%0d", k), 64'({cpuRdEmpty, cpuRdData}),
                        64'({1'b0, 16'hA001 + 16'(k)}));
        end
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("resfull_drained", 64'({cpuRdEmpty, cpuRdData, errUnderflow}),
                    64'({1'b1, 16'h0000, 1'b0}));

        // ---- reset in mid-packet --------------------------------------------
        doReset("reset_mid_pre");
        applyStimulus(1'b1, 16'h1003, 1'b0, 1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b1, 16'h1111, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("mid_hdr", 64'(actCmd()), 64'(packCmd(1, 16'h1003, 1, 0, 1, 0)));
        applyStimulus(1'b1, 16'h2222, 1'b1, 1'b1, 16'h5555, 1'b0);
        checkOutput("mid_pay", 64'(actCmd()), 64'(packCmd(1, 16'h1111, 0, 0, 1, 0)));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("mid_state", 64'({actCmd(), cpuRdEmpty, errUnderflow}),
                    64'({packCmd(1, 16'h2222, 0, 0, 1, 0), 1'b0, 1'b1}));
        doReset("reset_mid_packet");
        applyStimulus(1'b1, 16'h2000, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("post_reset_idle", 64'(actCmd()), 64'(packCmd(0, 16'h0000, 0, 0, 0, 0)));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("post_reset_hdr", 64'(actCmd()), 64'(packCmd(1, 16'h2000, 1, 1, 1, 0)));
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("post_reset_accept", 64'(actCmd()), 64'(packCmd(1, 16'h2000, 1, 1, 1, 0)));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("post_reset_done", 64'(actCmd()), 64'(packCmd(0, 16'h0000, 0, 0, 0, 0)));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
